ddr_wr_buf_reader: RTL and testbench
====================================

# ddr_wr_buf_reader

Drains one write burst from the arbiter's dual-port LSRAM write-data buffer and presents it as an AXI4 write-data (W) channel toward the DDR controller. It drives the buffer's read port (R_ADDR/R_EN, one-cycle registered read latency) and absorbs that latency plus WREADY back-pressure with a 2-entry output FIFO. The arbiter's write-path control starts one burst at a time, after the AW handshake.

## Interface
- DWIDTH, 64, data width of the buffer and of WDATA; a multiple of 8
- AWIDTH, 7, buffer address width; buffer depth is 2**AWIDTH
- CLK  in  1  single clock; every register is clocked on the rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  one-cycle pulse that starts a burst; sampled only in IDLE
- START_ADDR  in  AWIDTH  buffer address of beat 0
- BURST_LEN  in  8  AXI LEN encoding: beats = BURST_LEN+1, range 1..256
- BUSY  out  1  high from the cycle after START is accepted until DONE
- DONE  out  1  one-cycle pulse after the WLAST beat is accepted
- ERR  out  1  sticky protocol-error flag (see Configuration)
- RAM_R_ADDR  out  AWIDTH  buffer read address
- RAM_R_EN  out  1  buffer read enable
- RAM_R_DATA  in  DWIDTH  buffer read data; valid the cycle after RAM_R_EN
- WDATA  out  DWIDTH  AXI4 write data
- WSTRB  out  DWIDTH/8  byte strobes; all ones
- WLAST  out  1  marks the final beat of the burst
- WVALID  out  1  AXI4 valid
- WREADY  in  1  AXI4 ready

## Operation
- FSM states are IDLE, STREAM and FLUSH.
- IDLE -> STREAM on START. On that edge, latch the address from START_ADDR, load rd_left = BURST_LEN+1 and wr_left = BURST_LEN+1, and set BUSY.
- STREAM: issue a read (RAM_R_EN=1, RAM_R_ADDR=addr, then addr+1) while rd_left>0 and fifo_cnt + rd_pend - pop < 2.
  - pop means WVALID & WREADY in this cycle.
  - rd_pend is the 1-bit registered copy of RAM_R_EN.
  - When rd_pend=1, RAM_R_DATA is pushed into the FIFO. A push and a pop can occur in the same cycle.
- Addresses wrap modulo 2**AWIDTH. START_ADDR + BURST_LEN crossing the top of the buffer is legal.
- STREAM -> FLUSH when the final read has been issued (rd_left reaches 0).
- FLUSH -> IDLE on the pop of the WLAST beat. On that edge DONE pulses and BUSY clears.
- WVALID = (fifo_cnt != 0). WDATA is the FIFO head. WLAST = WVALID & (wr_left == 1). wr_left decrements on each pop.
- AXI rule: once WVALID is high, WVALID, WDATA and WLAST stay stable until WREADY is sampled high.
- Counters: rd_left and wr_left are 9 bits, so that 256 beats fit.
- Reset: all outputs go to 0, FSM to IDLE, FIFO empty, rd_pend=0, ERR=0.
  - Reset mid-burst abandons the burst. No DONE is produced.
  - Read data already in flight is discarded, because rd_pend is cleared.
- START while BUSY is ignored.

## Timing
- START is sampled in cycle 0. The first RAM_R_EN is in cycle 1. The FIFO push is at the end of cycle 2. WVALID is first high in cycle 3, so first-beat latency is 3 cycles.
- With WREADY held high, one beat is transferred per cycle with no bubbles. An N-beat burst has its WLAST handshake in cycle N+2 and DONE in cycle N+3.
- When WREADY drops, at most one additional read is issued and the FIFO fills to 2. No data is lost or repeated.
- The earliest next START is the cycle in which DONE is high.

## Configuration
- Macro: DDR_WR_BUF_RD_CHK_EN.
- Defined:
  - ERR sets on any of the following: START while BUSY; WREADY high for a cycle in IDLE; a FIFO push while fifo_cnt==2 (internal invariant).
  - ERR clears only on RESET.
- Undefined: ERR is tied to 0 and the check logic is not compiled.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, STREAM, FLUSH);
  - the localparam FIFO_DEPTH = 2;
  - the burst-length width constant LEN_W = 8.
- One sub-module: ddr_wr_buf_skid_fifo, a 2-entry register FIFO with push/pop/count, parameterised by DWIDTH.

## Test plan
- Single beat: START, START_ADDR=5, BURST_LEN=0, WREADY=1, RAM holding 0xA5 at address 5 -> RAM_R_EN only in cycle 1, WVALID+WLAST with WDATA=0xA5 in cycle 3, DONE in cycle 4.
- Full-rate burst: BURST_LEN=15, WREADY=1, RAM[i]=i -> 16 consecutive beats with data 0..15, WLAST on beat 15 only, DONE 1 cycle later.
- Back-pressure: BURST_LEN=7, WREADY toggling 1,0,0,1,… -> data order 0..7 intact, WDATA stable while stalled, fifo_cnt never exceeds 2.
- Wrap: AWIDTH=7, START_ADDR=126, BURST_LEN=3 -> read addresses 126, 127, 0, 1.
- Reset mid-burst: assert RESET after 3 beats of a 16-beat burst -> all outputs 0 at once. A fresh burst afterwards streams correctly with no stale beat.
- With DDR_WR_BUF_RD_CHK_EN: START while BUSY -> ERR=1 held until RESET, and the current burst completes unaffected.

Source files
------------

// File: rtl/ddr_wr_buf_reader_pkg.sv
// ddr_wr_buf_reader_pkg
// Shared definitions for the DDR write-buffer reader.
// - wr_state_e : burst FSM states (IDLE, STREAM, FLUSH)
// - FIFO_DEPTH : depth of the output skid FIFO
// - LEN_W      : AXI LEN field width
// - beats_f    : converts an AXI LEN encoding into a 9-bit beat count
package ddr_wr_buf_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } wr_state_e;

    localparam int FIFO_DEPTH = 2;
    localparam int LEN_W      = 8;

    // AXI LEN is beats-1; widen by one bit so 256 beats are representable.
    function automatic logic [LEN_W:0] beats_f(input logic [LEN_W-1:0] len);
        return {1'b0, len} + 9'd1;
    endfunction

endpackage

// File: rtl/ddr_wr_buf_skid_fifo.sv
// ddr_wr_buf_skid_fifo
// Two-entry register FIFO that absorbs the buffer read latency and W-channel
// back-pressure. The head entry does not move while a push lands in the
// other slot, which keeps WDATA stable during a stall.
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   PUSH, PUSH_DATA     write one entry (caller guarantees not full)
//   POP                 drop the head entry (caller guarantees not empty)
//   HEAD                current head entry
//   CNT                 occupancy 0..2
module ddr_wr_buf_skid_fifo
    import ddr_wr_buf_reader_pkg::*;
#(
    parameter int DWIDTH = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PUSH,
    input  logic [DWIDTH-1:0] PUSH_DATA,
    input  logic              POP,
    output logic [DWIDTH-1:0] HEAD,
    output logic [1:0]        CNT
);

    logic [DWIDTH-1:0] mem_r [FIFO_DEPTH];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        cnt_r;

    // Storage, pointers and occupancy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DWIDTH{1'b0}};
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            cnt_r    <= 2'd0;
        end else begin
            if (PUSH) begin
                mem_r[wr_ptr_r] <= PUSH_DATA;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (POP) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({PUSH, POP})
                2'b10:   cnt_r <= cnt_r + 2'd1;
                2'b01:   cnt_r <= cnt_r - 2'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign HEAD = mem_r[rd_ptr_r];
    assign CNT  = cnt_r;

endmodule

// File: rtl/ddr_wr_buf_reader.sv
// ddr_wr_buf_reader
// Drains one write burst from the LSRAM write-data buffer and presents it as
// an AXI4 W channel. Reads are throttled so that data in flight plus data
// held never exceeds the 2-entry skid FIFO.
// Ports:
//   CLK, RESET                    clock, asynchronous active-high reset
//   START, START_ADDR, BURST_LEN  burst request (LEN = beats-1), sampled in IDLE
//   BUSY, DONE, ERR               status; ERR is sticky
//   RAM_R_ADDR, RAM_R_EN          buffer read port (1-cycle read latency)
//   RAM_R_DATA                    buffer read data
//   WDATA, WSTRB, WLAST, WVALID   AXI4 write-data channel
//   WREADY                        AXI4 ready
// Optional: define DDR_WR_BUF_RD_CHK_EN to build the protocol checks that
// drive ERR; otherwise ERR is tied low.
module ddr_wr_buf_reader
    import ddr_wr_buf_reader_pkg::*;
#(
    parameter int DWIDTH = 64,
    parameter int AWIDTH = 7
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                START,
    input  logic [AWIDTH-1:0]   START_ADDR,
    input  logic [LEN_W-1:0]    BURST_LEN,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR,
    output logic [AWIDTH-1:0]   RAM_R_ADDR,
    output logic                RAM_R_EN,
    input  logic [DWIDTH-1:0]   RAM_R_DATA,
    output logic [DWIDTH-1:0]   WDATA,
    output logic [DWIDTH/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY
);

    wr_state_e         state_r;
    logic [AWIDTH-1:0] addr_r;
    logic [LEN_W:0]    rd_left_r;
    logic [LEN_W:0]    wr_left_r;
    logic              rd_pend_r;
    logic              busy_r;
    logic              done_r;
    logic [1:0]        fifo_cnt_s;
    logic [DWIDTH-1:0] fifo_head_s;
    logic              wvalid_s;
    logic              pop_s;
    logic              rd_en_s;

    assign wvalid_s = (fifo_cnt_s != 2'd0);
    assign pop_s    = wvalid_s & WREADY;

    // Read issue: only when the read cannot overflow the FIFO once it lands,
    // counting the read already in flight and the pop happening now.
    always_comb begin
        rd_en_s = 1'b0;
        if ((state_r == ST_STREAM) && (rd_left_r != 9'd0) &&
            (({1'b0, fifo_cnt_s} + {2'b00, rd_pend_r}) < (3'd2 + {2'b00, pop_s}))) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Burst FSM with read/write beat counters and status outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r   <= ST_IDLE;
            addr_r    <= {AWIDTH{1'b0}};
            rd_left_r <= 9'd0;
            wr_left_r <= 9'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (pop_s) begin
                wr_left_r <= wr_left_r - 9'd1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        state_r   <= ST_STREAM;
                        addr_r    <= START_ADDR;
                        rd_left_r <= beats_f(BURST_LEN);
                        wr_left_r <= beats_f(BURST_LEN);
                        busy_r    <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (rd_en_s) begin
                        // Natural wrap at the top of the buffer.
                        addr_r    <= addr_r + {{(AWIDTH-1){1'b0}}, 1'b1};
                        rd_left_r <= rd_left_r - 9'd1;
                        if (rd_left_r == 9'd1) begin
                            state_r <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (pop_s && (wr_left_r == 9'd1)) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Tracks the read in flight so its data is pushed the following cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_pend_r <= 1'b0;
        end else begin
            rd_pend_r <= rd_en_s;
        end
    end

    ddr_wr_buf_skid_fifo #(
        .DWIDTH (DWIDTH)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .PUSH      (rd_pend_r),
        .PUSH_DATA (RAM_R_DATA),
        .POP       (pop_s),
        .HEAD      (fifo_head_s),
        .CNT       (fifo_cnt_s)
    );

`ifdef DDR_WR_BUF_RD_CHK_EN
    logic err_r;

    // Sticky protocol-error flag; only RESET clears it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            err_r <= 1'b0;
        end else if ((START & busy_r) ||
                     ((state_r == ST_IDLE) && WREADY) ||
                     (rd_pend_r && (fifo_cnt_s == 2'd2))) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign ERR = err_r;
`else
    assign ERR = 1'b0;
`endif

    assign BUSY       = busy_r;
    assign DONE       = done_r;
    assign RAM_R_ADDR = addr_r;
    assign RAM_R_EN   = rd_en_s;
    assign WVALID     = wvalid_s;
    assign WDATA      = fifo_head_s;
    assign WLAST      = wvalid_s & (wr_left_r == 9'd1);
    assign WSTRB      = {(DWIDTH/8){1'b1}};

endmodule

// File: tb/tb_ddr_wr_buf_reader.sv
// Bench for ddr_wr_buf_reader: directed bursts against a bench-side buffer
// model and a beat-queue reference.
module tb_ddr_wr_buf_reader;

    localparam int DW = 64;
    localparam int AW = 7;
    localparam int DEPTH = 128;

    typedef struct {
        logic [DW-1:0] d;
        bit            last;
    } beat_t;

    logic            CLK = 1'b0;
    logic            RESET = 1'b1;
    logic            START = 1'b0;
    logic [AW-1:0]   START_ADDR = '0;
    logic [7:0]      BURST_LEN = 8'd0;
    logic            BUSY, DONE, ERR, RAM_R_EN, WLAST, WVALID;
    logic [AW-1:0]   RAM_R_ADDR;
    logic [DW-1:0]   RAM_R_DATA, WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WREADY = 1'b1;

    ddr_wr_buf_reader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .START_ADDR(START_ADDR),
        .BURST_LEN(BURST_LEN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .RAM_R_ADDR(RAM_R_ADDR), .RAM_R_EN(RAM_R_EN), .RAM_R_DATA(RAM_R_DATA),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY)
    );

    always #5 CLK = ~CLK;

    // Buffer with a one-cycle registered read.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge CLK) begin
        if (RAM_R_EN) RAM_R_DATA <= ram[RAM_R_ADDR];
    end

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;

    // Reference model state.
    beat_t         exp_q[$];
    int            addr_q[$];
    int            ra_log[$];
    bit            model_busy = 1'b0;
    bit            done_pend = 1'b0;
    bit            done_seen = 1'b0;
    int            outstanding = 0;
    int            max_out = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    int            start_cyc = 0, first_ren = -1, first_wv = -1, last_pop = -1, done_cyc = -1;
    int            ren_cnt = 0, beats = 0;
    logic [DW-1:0] first_data = '0, last_data = '0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic fail1(input string nm, input logic [63:0] got);
        n_vec++;
        n_mis++;
        $display("FAIL %s: got %0h expected none (cycle %0d)", nm, got, cyc);
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Compare process: checks DUT outputs against the beat-queue model.
    initial forever begin
        bit busy_now;
        @(negedge CLK);
        if (RESET) begin
            exp_q.delete();
            addr_q.delete();
            model_busy  = 1'b0;
            done_pend   = 1'b0;
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            busy_now = model_busy;
            check("busy", 64'(BUSY), 64'(busy_now));
            check("done", 64'(DONE), 64'(done_pend));
            if (DONE) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            done_pend = 1'b0;
            if (RAM_R_EN) begin
                if (addr_q.size() == 0) fail1("rd_extra", 64'(RAM_R_ADDR));
                else check("rd_addr", 64'(RAM_R_ADDR), 64'(addr_q.pop_front()));
                ra_log.push_back(int'(RAM_R_ADDR));
                ren_cnt++;
                if (first_ren < 0) first_ren = cyc;
                outstanding++;
            end
            if (prev_stall) begin
                check("hold_valid", 64'(WVALID), 64'd1);
                check("hold_data", WDATA, prev_data);
                check("hold_last", 64'(WLAST), 64'(prev_last));
            end
            if (WVALID) begin
                if (exp_q.size() == 0) begin
                    fail1("wvalid_spurious", WDATA);
                end else begin
                    check("wdata", WDATA, exp_q[0].d);
                    check("wlast", 64'(WLAST), 64'(exp_q[0].last));
                    check("wstrb", 64'(WSTRB), 64'hFF);
                    if (first_wv < 0) first_wv = cyc;
                    if (WREADY) begin
                        if (beats == 0) first_data = WDATA;
                        last_data = WDATA;
                        beats++;
                        outstanding--;
                        if (exp_q[0].last) begin
                            done_pend  = 1'b1;
                            model_busy = 1'b0;
                            last_pop   = cyc;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("wlast_idle", 64'(WLAST), 64'd0);
            end
            check("fifo_bound", 64'(outstanding > 2), 64'd0);
            if (outstanding > max_out) max_out = outstanding;
            prev_stall = WVALID & ~WREADY;
            prev_data  = WDATA;
            prev_last  = WLAST;
            if (START && !busy_now) begin
                for (int i = 0; i <= int'(BURST_LEN); i++) begin
                    int a;
                    beat_t b;
                    a = (int'(START_ADDR) + i) % DEPTH;
                    addr_q.push_back(a);
                    b.d = ram[a];
                    b.last = (i == int'(BURST_LEN));
                    exp_q.push_back(b);
                end
                model_busy = 1'b1;
                start_cyc  = cyc;
                first_ren  = -1;
                first_wv   = -1;
                last_pop   = -1;
                done_cyc   = -1;
                ren_cnt    = 0;
                beats      = 0;
                max_out    = 0;
                done_seen  = 1'b0;
                ra_log.delete();
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Runs until DONE is observed, optionally toggling WREADY 1,0,0,1.
    task automatic run(input bit bp, input int lim);
        logic [3:0] pat;
        pat = 4'b1001;
        for (int i = 0; i < lim; i++) begin
            if (bp) WREADY = pat[i % 4];
            step();
            if (done_seen) break;
        end
        if (!done_seen) fail1("timeout_done", 64'(cyc));
        WREADY = 1'b1;
        step();
    endtask

    task automatic burst(input int addr, input int len, input bit bp);
        START      = 1'b1;
        START_ADDR = addr[AW-1:0];
        BURST_LEN  = len[7:0];
        step();
        START = 1'b0;
        run(bp, 400);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_busy"}, 64'(BUSY), 64'd0);
        check({nm, "_done"}, 64'(DONE), 64'd0);
        check({nm, "_err"}, 64'(ERR), 64'd0);
        check({nm, "_wvalid"}, 64'(WVALID), 64'd0);
        check({nm, "_wlast"}, 64'(WLAST), 64'd0);
        check({nm, "_wdata"}, WDATA, 64'd0);
        check({nm, "_ren"}, 64'(RAM_R_EN), 64'd0);
        check({nm, "_raddr"}, 64'(RAM_R_ADDR), 64'd0);
    endtask

    initial begin
        int wrap_exp[4];
        wrap_exp = '{126, 127, 0, 1};
        for (int i = 0; i < DEPTH; i++) ram[i] = 64'(i);
        RAM_R_DATA = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_idle_outputs("reset");
        RESET = 1'b0;
        step();

        // Single beat.
        ram[5] = 64'hA5;
        burst(5, 0, 1'b0);
        check("t1_ren_cnt", 64'(ren_cnt), 64'd1);
        check("t1_ren_cyc", 64'(first_ren - start_cyc), 64'd1);
        check("t1_wvalid_cyc", 64'(first_wv - start_cyc), 64'd3);
        check("t1_wlast_cyc", 64'(last_pop - start_cyc), 64'd3);
        check("t1_done_cyc", 64'(done_cyc - start_cyc), 64'd4);
        check("t1_data", first_data, 64'hA5);
        ram[5] = 64'd5;

        // Full-rate 16-beat burst with an ignored START mid-burst.
        START = 1'b1; START_ADDR = 7'd0; BURST_LEN = 8'd15;
        step();
        START = 1'b0;
        step();
        step();
        START = 1'b1; START_ADDR = 7'd99; BURST_LEN = 8'd2;
        step();
        START = 1'b0;
        run(1'b0, 400);
        check("t2_beats", 64'(beats), 64'd16);
        check("t2_first", first_data, 64'd0);
        check("t2_last", last_data, 64'd15);
        check("t2_no_bubble", 64'(last_pop - first_wv), 64'd15);
        check("t2_wlast_cyc", 64'(last_pop - start_cyc), 64'd18);
        check("t2_done_cyc", 64'(done_cyc - start_cyc), 64'd19);
`ifdef DDR_WR_BUF_RD_CHK_EN
        check("t2_err", 64'(ERR), 64'd1);
`else
        check("t2_err", 64'(ERR), 64'd0);
`endif

        // Back-pressure.
        burst(0, 7, 1'b1);
        check("t3_beats", 64'(beats), 64'd8);
        check("t3_first", first_data, 64'd0);
        check("t3_last", last_data, 64'd7);
        check("t3_max_out", 64'(max_out <= 2), 64'd1);

        // Address wrap.
        burst(126, 3, 1'b0);
        check("t4_nreads", 64'(ra_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < ra_log.size(); i++)
            check("t4_raddr", 64'(ra_log[i]), 64'(wrap_exp[i]));
        check("t4_last", last_data, 64'd1);

        // Reset mid-burst, then a fresh burst.
        START = 1'b1; START_ADDR = 7'd0; BURST_LEN = 8'd15;
        step();
        START = 1'b0;
        for (int i = 0; i < 50 && beats < 3; i++) step();
        check("t5_three_beats", 64'(beats >= 3), 64'd1);
        RESET = 1'b1;
        #1;
        check_idle_outputs("t5_rst");
        step();
        RESET = 1'b0;
        step();
        burst(40, 4, 1'b0);
        check("t5_beats", 64'(beats), 64'd5);
        check("t5_first", first_data, 64'd40);
        check("t5_last", last_data, 64'd44);
        check("t5_done_cyc", 64'(done_cyc - start_cyc), 64'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
